serial_byte_loader: RTL and testbench
=====================================

# serial_byte_loader

Upstream feeder for the 8-bit latch bank. Deserialises a framed serial bit stream into a parallel word and drives the bank's data and enable inputs. The bank's `d` bus connects to this block's `d` output, and the bank's `enable` input connects to this block's `enable` output. A word is only ever presented to the bank complete and stable, together with a bounded enable pulse.

## Interface
- `WIDTH`, 8: parallel word width; must equal the latch bank width.
- `LSB_FIRST`, 1: 1 means the first serial bit lands in `d[0]`; 0 means it lands in `d[WIDTH-1]`.
- `HOLD_CYCLES`, 1: number of cycles `enable` stays high per word; range 1–15.

- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  frame-start strobe.
- `sdata`  in  1  serial data bit.
- `sdata_valid`  in  1  `sdata` is sampled on this edge.
- `d`  out  WIDTH  assembled word (to the latch bank).
- `enable`  out  1  latch-enable pulse (to the latch bank).
- `busy`  out  1  high from frame start until the enable pulse ends.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted by `start`.

## Operation
- FSM states: IDLE, SHIFT, LOAD.
- **IDLE**
  - `start`=1 → SHIFT. The bit counter and shift register clear to 0.
  - `sdata_valid` is ignored in IDLE, including in the same cycle as `start`.
- **SHIFT**
  - Each cycle with `sdata_valid`=1 shifts `sdata` into the shift register and increments the counter.
  - Cycles with `sdata_valid`=0 change nothing.
- **SHIFT → LOAD**
  - Taken on the edge that samples the WIDTH-th valid bit.
  - On that same edge, `d` is loaded with the full word and the hold counter is loaded with HOLD_CYCLES.
- **SHIFT, `start`=1**
  - Restart: the counter and shift register clear and the state stays SHIFT.
  - `frame_err` pulses for 1 cycle.
  - `start` has priority over `sdata_valid`, so any bit presented in that cycle is discarded.
- **LOAD**
  - `enable`=1 for exactly HOLD_CYCLES cycles, then the state returns to IDLE.
  - `start` and `sdata_valid` are ignored in LOAD, with no error.
- **`d` behaviour**
  - `d` is a separate output register, distinct from the shift register.
  - It changes only on SHIFT→LOAD or on reset.
  - It holds its last word indefinitely, so the latch bank never sees partial data.
- **Bit order**
  - LSB_FIRST=1: bit k of the frame (k = 0 first) → `d[k]`.
  - LSB_FIRST=0: bit k → `d[WIDTH-1-k]`.
- **Reset** (synchronous, has priority over everything)
  - state=IDLE, `d`=0, `enable`=0, `busy`=0, `frame_err`=0, counters=0.
  - A reset mid-SHIFT or mid-LOAD discards the frame and cuts the enable pulse.
- **Outputs**
  - `busy` = (state != IDLE), registered.
  - All outputs are registered; none has a combinational path from the inputs.

## Timing
- Every output takes its reset value in the cycle after the edge where `reset`=1 is sampled.
- `start` sampled at edge E → `busy`=1 from E.
- WIDTH-th valid bit sampled at edge N → `d` carries the new word and `enable`=1 from N. `enable` falls at edge N+HOLD_CYCLES, together with `busy`.
- Minimum frame latency, with `sdata_valid` held high starting the cycle after `start`:
  - WIDTH+1 cycles from `start` to `enable`.
  - WIDTH+1+HOLD_CYCLES cycles from `start` back to IDLE.
- The earliest next `start` is accepted in the cycle where `busy` is first low.
- `d` is stable throughout the whole `enable` window and after it.
- `frame_err` is high only in the single cycle following the aborting `start` edge.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-traffic → `d`=8'h00, `enable`=0, `busy`=0, `frame_err`=0.
- **LSB-first, contiguous:** LSB_FIRST=1; `start`, then bits 1,1,0,0,0,0,0,0 with `sdata_valid` held high → `d`=8'h03, one `enable` pulse 9 cycles after `start`, then `busy` falls.
- **MSB-first, with gaps:** LSB_FIRST=0; same bits with `sdata_valid` low on alternate cycles → `d`=8'hC0, exactly one `enable` pulse, no extra bits counted.
- **Abort mid-frame:** `start`, 3 bits, `start` again, then bits for 8'h5A → one `frame_err` pulse and `d`=8'h5A.
- **Reset mid-frame:** `reset` after 5 bits → no `enable`, `d`=8'h00; a following full frame for 8'hFF → `d`=8'hFF.
- **Hold length and ignored inputs:** HOLD_CYCLES=3 → `enable` high for exactly 3 cycles; `start` and `sdata_valid` pulsed during LOAD are ignored, `frame_err`=0, `d` unchanged.

Source files
------------

// File: rtl/serial_byte_loader.sv
// Deserialises a framed serial bit stream into a parallel word for the latch bank,
// presenting it complete on a registered d bus together with a bounded enable pulse.
module serial_byte_loader #(
  parameter int WIDTH       = 8,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             sdata_i,
  input  logic             sdata_valid_i,
  output logic [WIDTH-1:0] d_o,
  output logic             enable_o,
  output logic             busy_o,
  output logic             frame_err_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    HOLD_CNT = 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dReg_q, dReg_d;
  logic [3:0]       holdCnt_q, holdCnt_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             frameErr_q, frameErr_d;
  logic [WIDTH-1:0] shiftIn;

  // The first serial bit must end up in d[0] (LSB-first) or d[WIDTH-1] (MSB-first).
  always_comb begin
    if (LSB_FIRST) begin
      shiftIn = {sdata_i, shift_q[WIDTH-1:1]};
    end else begin
      shiftIn = {shift_q[WIDTH-2:0], sdata_i};
    end
  end

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    dReg_d     = dReg_q;
    holdCnt_d  = holdCnt_q;
    frameErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SHIFT;
          bitCnt_d = '0;
          shift_d  = '0;
        end
      end
      SHIFT: begin
        if (start_i) begin
          bitCnt_d   = '0;
          shift_d    = '0;
          frameErr_d = 1'b1;
        end else if (sdata_valid_i) begin
          shift_d  = shiftIn;
          bitCnt_d = bitCnt_q + CNT_ONE;
          if (bitCnt_q == LAST_BIT) begin
            state_d   = LOAD;
            dReg_d    = shiftIn;
            holdCnt_d = HOLD_CNT;
          end
        end
      end
      LOAD: begin
        // Inputs are deliberately ignored here; only the hold countdown matters.
        if (holdCnt_q <= 4'd1) begin
          state_d   = IDLE;
          holdCnt_d = 4'd0;
        end else begin
          holdCnt_d = holdCnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    enable_d = (state_d == LOAD);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      dReg_q     <= '0;
      holdCnt_q  <= 4'd0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      dReg_q     <= dReg_d;
      holdCnt_q  <= holdCnt_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign d_o         = dReg_q;
  assign enable_o    = enable_q;
  assign busy_o      = busy_q;
  assign frame_err_o = frameErr_q;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Drives two loader instances (LSB-first/hold 1 and MSB-first/hold 3) from shared inputs
// and compares every output each cycle with a frame-level reference model.
module tb_serial_byte_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       sdata = 1'b0;
  logic       sdataValid = 1'b0;
  logic [7:0] dA, dB;
  logic       enableA, enableB, busyA, busyB, errA, errB;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state, index 0 = instance A, 1 = instance B.
  bit         inFrame[2];
  int         nBits[2];
  logic [7:0] frameBits[2];
  logic [7:0] expD[2];
  int         loadLeft[2];
  bit         expErr[2];

  always #5 clk = ~clk;

  serial_byte_loader #(.WIDTH(8), .LSB_FIRST(1'b1), .HOLD_CYCLES(1)) dutA (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sdata_i(sdata),
    .sdata_valid_i(sdataValid), .d_o(dA), .enable_o(enableA),
    .busy_o(busyA), .frame_err_o(errA)
  );

  serial_byte_loader #(.WIDTH(8), .LSB_FIRST(1'b0), .HOLD_CYCLES(3)) dutB (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sdata_i(sdata),
    .sdata_valid_i(sdataValid), .d_o(dB), .enable_o(enableB),
    .busy_o(busyB), .frame_err_o(errB)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Frame-level rules: collect bits while framed, publish the word for HOLD cycles.
  task automatic modelStep(input logic st, input logic sd, input logic sv, input logic rs);
    for (int i = 0; i < 2; i++) begin
      int hold;
      hold = (i == 0) ? 1 : 3;
      expErr[i] = 1'b0;
      if (rs) begin
        inFrame[i] = 1'b0;
        nBits[i] = 0;
        loadLeft[i] = 0;
        expD[i] = 8'h00;
      end else if (loadLeft[i] > 0) begin
        loadLeft[i]--;
      end else if (inFrame[i]) begin
        if (st) begin
          nBits[i] = 0;
          expErr[i] = 1'b1;
        end else if (sv) begin
          frameBits[i][nBits[i]] = sd;
          nBits[i]++;
          if (nBits[i] == 8) begin
            for (int k = 0; k < 8; k++) begin
              if (i == 0) expD[i][k] = frameBits[i][k];
              else        expD[i][7-k] = frameBits[i][k];
            end
            loadLeft[i] = hold;
            inFrame[i] = 1'b0;
            nBits[i] = 0;
          end
        end
      end else if (st) begin
        inFrame[i] = 1'b1;
        nBits[i] = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sd, input logic sv, input logic rs);
    start = st;
    sdata = sd;
    sdataValid = sv;
    reset = rs;
    @(posedge clk);
    modelStep(st, sd, sv, rs);
    #1;
    checkOutput("A.d", dA, expD[0]);
    checkOutput("A.enable", {7'd0, enableA}, {7'd0, loadLeft[0] > 0});
    checkOutput("A.busy", {7'd0, busyA}, {7'd0, inFrame[0] || (loadLeft[0] > 0)});
    checkOutput("A.frame_err", {7'd0, errA}, {7'd0, expErr[0]});
    checkOutput("B.d", dB, expD[1]);
    checkOutput("B.enable", {7'd0, enableB}, {7'd0, loadLeft[1] > 0});
    checkOutput("B.busy", {7'd0, busyB}, {7'd0, inFrame[1] || (loadLeft[1] > 0)});
    checkOutput("B.frame_err", {7'd0, errB}, {7'd0, expErr[1]});
  endtask

  task automatic sendFrame(input logic [7:0] bits8, input bit gaps);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, bits8[k], 1'b1, 1'b0);
      if (gaps) applyStimulus(1'b0, ~bits8[k], 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      inFrame[i] = 1'b0; nBits[i] = 0; frameBits[i] = 8'h00;
      expD[i] = 8'h00; loadLeft[i] = 0; expErr[i] = 1'b0;
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Contiguous frame, bits 1,1,0,0,0,0,0,0.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    sendFrame(8'h03, 1'b0);
    checkOutput("plan.lsb.d", dA, 8'h03);
    checkOutput("plan.lsb.enable", {7'd0, enableA}, 8'h01);
    checkOutput("plan.msb.d", dB, 8'hC0);
    idle(5);

    // Same bits with alternate invalid cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendFrame(8'h03, 1'b1);
    idle(5);
    checkOutput("plan.gaps.msb.d", dB, 8'hC0);

    // Abort after 3 bits, then a full frame.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("plan.abort.err", {7'd0, errA}, 8'h01);
    sendFrame(8'h5A, 1'b0);
    checkOutput("plan.abort.d", dA, 8'h5A);
    idle(5);

    // Reset after 5 bits, then an all-ones frame.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("plan.reset.d", dA, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendFrame(8'hFF, 1'b0);
    checkOutput("plan.ff.d", dB, 8'hFF);
    idle(5);

    // Inputs pulsed while the hold-3 instance is loading.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendFrame(8'hA5, 1'b0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("plan.hold.errB", {7'd0, errB}, 8'h00);
      checkOutput("plan.hold.enB", {7'd0, enableB}, 8'h01);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("plan.hold.endB", {7'd0, enableB}, 8'h00);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    for (int n = 0; n < 800; n++) begin
      applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 79) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
